// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the receive-side serial-to-parallel stage.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  localparam int              WIDTH_DEF    = 8;
  localparam logic [7:0]      COMMA_DEF    = 8'hBC;
  localparam int              BC_COUNT_DEF = 4;

endpackage

// File: rtl/serial_par_rx_l2_comma_detect.sv
// Combinational compare of the candidate byte against the comma symbol.
module comma_detect #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = 8'hBC
) (
  input  logic [WIDTH-1:0] word,
  output logic             is_comma
);

  assign is_comma = (word == COMMA);

endmodule

// File: rtl/serial_par_rx_l2.sv
// Serial-to-parallel receiver: comma hunt, alignment confirm, byte output
// held one byte period for the downstream 1:2 demux.
//
//  state  | meaning
//  HUNT   | bit-by-bit search for a comma in the shift window
//  SYNC   | counting consecutive commas on the tentative byte boundary
//  ACTIVE | aligned (sticky until reset); emit payload bytes on each boundary
module serial_par_rx_l2
  import serial_rx_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COMMA    = COMMA_DEF,
  parameter int               BC_COUNT = BC_COUNT_DEF
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_strobe,
  output logic             active
);

  localparam int BCW = $clog2(BC_COUNT + 1);
  localparam int BTW = $clog2(WIDTH);
  localparam logic [BTW-1:0] LAST_BIT = BTW'(WIDTH - 1);
  localparam logic [BCW-1:0] BC_TARGET = BCW'(BC_COUNT);

  rx_state_e        state;
  logic [WIDTH-1:0] shift_q;
  logic [BTW-1:0]   bit_cnt;
  logic [BCW-1:0]   bc_cnt;

  logic [WIDTH-1:0] nxt;
  logic             is_comma;
  logic             boundary;
  logic [BCW-1:0]   bc_inc;
  logic [BTW-1:0]   bit_cnt_nxt;

  assign nxt         = {shift_q[WIDTH-2:0], data_in};
  assign boundary    = (bit_cnt == LAST_BIT);
  assign bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
  assign bc_inc      = (bc_cnt == BC_TARGET) ? bc_cnt : bc_cnt + 1'b1;

  comma_detect #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_comma_detect (
    .word     (nxt),
    .is_comma (is_comma)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= HUNT;
      shift_q     <= '0;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      shift_q     <= nxt;
      byte_strobe <= 1'b0;
      case (state)
        HUNT: begin
          if (is_comma) begin
            bit_cnt <= '0;
            bc_cnt  <= BCW'(1);
            if (BC_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          bit_cnt <= bit_cnt_nxt;
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_inc;
              // The completing boundary itself emits no strobe or data.
              if (bc_inc == BC_TARGET) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              bc_cnt <= '0;
              state  <= HUNT;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt_nxt;
          if (boundary) begin
            byte_strobe <= 1'b1;
            if (is_comma) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= nxt;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
